// File: rtl/up_timer.sv
// Programmable up-counting timer: counts 0..limit on i_en ticks, pulses o_carry
// at terminal count, and runs either periodic (auto-wrap) or one-shot.
module up_timer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEF_LIMIT = 15,
    parameter bit          USE_DEF   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] DEF_L = WIDTH'(DEF_LIMIT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] eff_limit;

    always_comb begin
        eff_limit = i_limit;
        if (USE_DEF && (i_limit == '0)) begin
            eff_limit = DEF_L;
        end
    end

    // Priority: stop over start, start over a coincident tick.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        carry_d = 1'b0;
        if (i_stop) begin
            state_d = S_IDLE;
            data_d  = '0;
        end else if (i_start) begin
            state_d = S_RUN;
            data_d  = '0;
            limit_d = eff_limit;
            mode_d  = i_mode;
        end else if ((state_q == S_RUN) && i_en) begin
            if (data_q == limit_q) begin
                carry_d = 1'b1;
                if (mode_q) begin
                    data_d = '0;
                end else begin
                    state_d = S_DONE;
                end
            end else begin
                data_d = data_q + WIDTH'(1);
            end
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_data  = data_q;
    assign o_carry = carry_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
